ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder with a valid/ready handshake. It extends the fixed 32-bit, purely combinational prefix-level adder to any width. Pipeline registers can be placed after any prefix level, and backpressure is supported. It sits in the datapath wherever a multi-cycle, high-Fmax add of operand pairs with carry-in is needed.

---
 rtl/ks_pkg.sv | 37 +++
 rtl/ks_prefix_level.sv | 28 ++
 rtl/ks_adder_pipe.sv | 150 +++++++++++++++
 tb/tb_ks_adder_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg
// Shared definitions for the pipelined Kogge-Stone adder.
//   KS_MAX_WIDTH   : widest operand the adder is built for
//   ks_pg_t        : generate/propagate pair at full width
//   ks_levels      : number of prefix levels needed to span a width
//   ks_regs_before : how many register stages a mask places below a level
package ks_pkg;

  localparam int KS_MAX_WIDTH = 64;

  typedef struct packed {
    logic [KS_MAX_WIDTH-1:0] g;
    logic [KS_MAX_WIDTH-1:0] p;
  } ks_pg_t;

  // Smallest L with 2**L >= width; 64 bits needs at most six levels.
  function automatic int ks_levels(input int width);
    int lv;
    lv = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < width) lv = i + 1;
    end
    return lv;
  endfunction

  // Number of set mask bits strictly below 'level'. Used both to number
  // the register stage that follows a level and to count total stages.
  function automatic int ks_regs_before(input logic [31:0] mask, input int level);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < level && mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level
// One combinational Kogge-Stone prefix level at distance DIST.
//   g_in, p_in   : group generate/propagate entering the level
//   g_out, p_out : group generate/propagate leaving the level
// Bits at or above DIST get a black cell; lower bits pass straight through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  // Pass-through is the default so low bits act as buffers.
  always_comb begin
    g_out = g_in;
    p_out = p_in;
    for (int i = DIST; i < WIDTH; i++) begin
      g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      p_out[i] = p_in[i] & p_in[i-DIST];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe
// Parametrised pipelined Kogge-Stone adder with valid/ready flow control.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready: result handshake (out_sum, out_cout[, out_ovf])
// WIDTH sets the operand width (2..64). PIPE_MASK bit k inserts a register
// stage after prefix level k; the output register is always present, so
// the pipeline holds 1 + popcount(PIPE_MASK[LEVELS-1:0]) results.
// Defining KS_OVERFLOW_EN adds the registered signed-overflow output out_ovf.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] PIPE_MASK = 32'b01010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef KS_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int STAGES = 1 + ks_regs_before(PIPE_MASK, LEVELS);

  // Index j holds the values entering prefix level j; index LEVELS is the
  // fully resolved carry vector. r is the raw a^b needed for the final sum.
  logic [WIDTH-1:0] lvl_g [LEVELS+1];
  logic [WIDTH-1:0] lvl_p [LEVELS+1];
  logic [WIDTH-1:0] lvl_r [LEVELS+1];
  logic             lvl_c [LEVELS+1];

  logic [STAGES:0]   en;
  logic [STAGES-1:0] stage_v;
  logic [STAGES-1:0] stage_v_in;
  logic [WIDTH-1:0]  sum_nx;

  // Carry-in folds into bit 0 so the prefix tree needs no special case.
  assign lvl_r[0] = in_a ^ in_b;
  assign lvl_p[0] = in_a ^ in_b;
  assign lvl_g[0] = (in_a & in_b) | {{(WIDTH-1){1'b0}}, (in_a[0] ^ in_b[0]) & in_cin};
  assign lvl_c[0] = in_cin;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    en         = '0;
    en[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      en[s] = !stage_v[s] | en[s+1];
    end
  end

  assign in_ready = en[0] & !rst;

  always_comb begin
    stage_v_in    = '0;
    stage_v_in[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      stage_v_in[s] = stage_v[s-1];
    end
  end

  // Valid bits are the only pipeline state that needs reset; data regs
  // behind a cleared valid are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (en[s]) stage_v[s] <= stage_v_in[s];
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] g_nx;
    logic [WIDTH-1:0] p_nx;

    ks_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_level (
      .g_in (lvl_g[k]),
      .p_in (lvl_p[k]),
      .g_out(g_nx),
      .p_out(p_nx)
    );

    if (PIPE_MASK[k]) begin : g_reg
      localparam int STG = ks_regs_before(PIPE_MASK, k);
      logic [WIDTH-1:0] g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] r_q;
      logic             c_q;

      // Intermediate stage register, advancing with its stage enable.
      always_ff @(posedge clk) begin
        if (en[STG]) begin
          g_q <= g_nx;
          p_q <= p_nx;
          r_q <= lvl_r[k];
          c_q <= lvl_c[k];
        end
      end

      assign lvl_g[k+1] = g_q;
      assign lvl_p[k+1] = p_q;
      assign lvl_r[k+1] = r_q;
      assign lvl_c[k+1] = c_q;
    end else begin : g_comb
      assign lvl_g[k+1] = g_nx;
      assign lvl_p[k+1] = p_nx;
      assign lvl_r[k+1] = lvl_r[k];
      assign lvl_c[k+1] = lvl_c[k];
    end
  end

  // G[i] is the carry out of bit i, so bit i of the sum uses G[i-1].
  assign sum_nx = lvl_r[LEVELS] ^ {lvl_g[LEVELS][WIDTH-2:0], lvl_c[LEVELS]};

  // Output register holds its value while stalled (en low).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef KS_OVERFLOW_EN
      out_ovf  <= 1'b0;
`endif
    end else if (en[STAGES-1]) begin
      out_sum  <= sum_nx;
      out_cout <= lvl_g[LEVELS][WIDTH-1];
`ifdef KS_OVERFLOW_EN
      out_ovf  <= lvl_g[LEVELS][WIDTH-2] ^ lvl_g[LEVELS][WIDTH-1];
`endif
    end
  end

  assign out_valid = stage_v[STAGES-1];

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe
// Scoreboard bench for ks_adder_pipe at WIDTH=32, PIPE_MASK='b01010 (3 stages).
// Stimulus pushes expected results; an independent monitor pops and compares.
module tb_ks_adder_pipe;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
`ifdef KS_OVERFLOW_EN
  logic        out_ovf;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rnd_done = 0;

  logic [31:0] dir_a    [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'hAAAAAAAA};
  logic [31:0] dir_b    [6] = '{32'h00000000, 32'h00000001, 32'h80000000, 32'h87654321, 32'hFFFFFFFF, 32'h55555555};
  logic        dir_cin  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] dir_sum  [6] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h99999999, 32'hFFFFFFFF, 32'h00000000};
  logic        dir_cout [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        dir_ovf  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  ks_adder_pipe #(
    .WIDTH    (32),
    .PIPE_MASK(32'b01010)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
`ifdef KS_OVERFLOW_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends even if the DUT wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offer one operand pair until accepted; the expected result is queued
  // in the cycle the transfer happens.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic [31:0] esum, input logic ecout, input logic eovf,
                               input bit lat);
    exp_t e;
    int   waited;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        e.acc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        checkOutput("accept_timeout", {63'b0, in_ready}, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic applyRandom();
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [32:0] full;
    logic        ovf;
    a    = $urandom;
    b    = $urandom;
    cin  = 1'($urandom_range(0, 1));
    full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    applyStimulus(a, b, cin, full[31:0], full[32], ovf, 1'b0);
  endtask

  // Monitor: pops on every output transfer and checks that a stalled
  // output does not change before it is taken.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_sum;
    logic        prev_cout;
    prev_stall = 0;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_sum", {32'b0, out_sum}, {32'b0, prev_sum});
          checkOutput("hold_cout", {63'b0, out_cout}, {63'b0, prev_cout});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", {63'b0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("sum", {32'b0, out_sum}, {32'b0, e.sum});
            checkOutput("cout", {63'b0, out_cout}, {63'b0, e.cout});
`ifdef KS_OVERFLOW_EN
            checkOutput("ovf", {63'b0, out_ovf}, {63'b0, e.ovf});
`endif
            if (e.lat) checkOutput("latency", 64'(cyc - e.acc), 64'(S));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
        prev_cout  = out_cout;
      end
    end
  end

  // Main sequence: reset, directed vectors, backpressure, mid-flight reset,
  // then a randomised handshake run checked against a + b + cin.
  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_out_sum", {32'b0, out_sum}, 64'd0);
    checkOutput("rst_out_cout", {63'b0, out_cout}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd0);
`ifdef KS_OVERFLOW_EN
    checkOutput("rst_out_ovf", {63'b0, out_ovf}, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(dir_a[i], dir_b[i], dir_cin[i], dir_sum[i], dir_cout[i], dir_ovf[i], 1'b1);
      repeat (4) begin
        @(posedge clk);
        #1;
      end
    end

    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          applyStimulus(32'(i), 32'(10 * i), 1'b0, 32'(11 * i), 1'b0, 1'b0, 1'b0);
          if (i == 3) begin
            @(negedge clk);
            checkOutput("in_ready_full", {63'b0, in_ready}, 64'd0);
            checkOutput("out_valid_full", {63'b0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_drain", 64'(sb.size()), 64'd0);

    applyStimulus(32'd100, 32'd1, 1'b0, 32'd101, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd200, 32'd2, 1'b0, 32'd202, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_mid_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_mid_out_sum", {32'b0, out_sum}, 64'd0);
    checkOutput("rst_mid_in_ready_after", {63'b0, in_ready}, 64'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyRandom();
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
